// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder slice.
// Holds the instruction-format enum that imm_generator also uses, plus the
// standard RV32 bit positions of the non-immediate instruction fields.
package inst_encoder_pkg;

  // Instruction format selector; values match imm_generator.
  typedef enum logic [2:0] {
    INST_NONE = 3'd0,
    INST_I    = 3'd1,
    INST_S    = 3'd2,
    INST_SB   = 3'd3,
    INST_UJ   = 3'd4,
    INST_U    = 3'd5
  } inst_t;

  // LSB positions of the fixed RV32 fields inside a 32-bit word.
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  // FIFO entry: {err, word}.
  localparam int unsigned ENTRY_W = 33;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with occupancy count.
// Ports: clk, nrst (async active-low), push/wdata (write side, ignored when
// full), pop (read side, ignored when empty), rdata (head entry),
// count (0..DEPTH), full, empty. DEPTH must be a power of two so the
// pointers wrap naturally.
module inst_fifo
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign count     = count_r;
  // Storage is reset so the head reads zero out of reset.
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs fields and an immediate into a 32-bit
// word (inverse of imm_generator), flags unrepresentable immediates and
// queues {err, word} in a small FIFO with valid/ready on both sides.
// Ports: clk, nrst; request side in_valid/in_ready with type_i, imm_i,
// opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i; consumer side
// out_valid/out_ready with out_inst, out_err; err_count (saturating,
// cleared by err_clr).
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  type_i,
  input  logic [31:0] imm_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  inst_t              type_s;
  logic [31:0]        word_s;
  logic               err_s;
  logic               accept_s;
  logic [ENTRY_W-1:0] head_s;
  logic [CNT_W-1:0]   count_s;
  logic               full_s;
  logic               empty_s;
  logic [7:0]         err_count_r;

  assign type_s = inst_t'(type_i);

  // Field packing, immediate scatter and legality check.
  always_comb begin
    word_s = 32'd0;
    word_s[OPCODE_LSB +: 7] = opcode_i;
    word_s[RD_LSB     +: 5] = rd_i;
    word_s[FUNCT3_LSB +: 3] = funct3_i;
    word_s[RS1_LSB    +: 5] = rs1_i;
    word_s[RS2_LSB    +: 5] = rs2_i;
    word_s[FUNCT7_LSB +: 7] = funct7_i;
    err_s = 1'b0;
    case (type_s)
      INST_I: begin
        word_s[31:20] = imm_i[11:0];
        err_s = (imm_i[31:11] != {21{imm_i[11]}});
      end
      INST_S: begin
        word_s[31:25] = imm_i[11:5];
        word_s[11:7]  = imm_i[4:0];
        err_s = (imm_i[31:11] != {21{imm_i[11]}});
      end
      INST_SB: begin
        word_s[31]    = imm_i[11];
        word_s[7]     = imm_i[10];
        word_s[30:25] = imm_i[9:4];
        word_s[11:8]  = imm_i[3:0];
        err_s = (imm_i[31:11] != {21{imm_i[11]}});
      end
      INST_UJ: begin
        // imm[10] lands in bit 31, so it doubles as the sign on decode.
        word_s[31:21] = imm_i[10:0];
        word_s[20]    = imm_i[11];
        word_s[19:12] = imm_i[19:12];
        err_s = (imm_i[31:20] != {12{imm_i[10]}});
      end
      INST_U: begin
        word_s[31:12] = imm_i[31:12];
        err_s = (imm_i[11:0] != 12'd0);
      end
      default: begin
        word_s = {25'd0, opcode_i};
        err_s  = 1'b1;
      end
    endcase
  end

  // Backpressure comes only from occupancy; a pop in the same cycle does
  // not free a slot for a push when full.
  assign in_ready = (count_s != CNT_W'(DEPTH));
  assign accept_s = in_valid & ~full_s;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (accept_s),
    .wdata ({err_s, word_s}),
    .pop   (out_ready),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = ~empty_s;
  assign out_inst  = head_s[31:0];
  assign out_err   = head_s[32];
  assign err_count = err_count_r;

  // Saturating error counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_count_r <= 8'd0;
    end else if (err_clr) begin
      err_count_r <= 8'd0;
    end else if (accept_s && err_s && (err_count_r != 8'd255)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

endmodule
